pipe_ctrl: RTL and testbench

- Hazard and stall controller that drives the enable and flush inputs of the four pipeline latches (if_dc, dc_ex, ex_mem, mem_wb) and the PC enable.
- Decides each cycle which stages advance, hold, or take a bubble, based on memory handshakes, a load-use hazard, EX-stage redirects and halt.
- Keeps a 3-state FSM plus saturating performance counters; sits in the datapath top beside the hazard/forwarding logic.

---
 rtl/pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pipe_ctrl                                                  |
// | Purpose : Pipeline hazard / stall controller. Drives the PC enable   |
// |           and the enable/flush controls of the if_dc, dc_ex, ex_mem  |
// |           and mem_wb latches from memory handshakes, load-use        |
// |           hazards, EX redirects and halt. Keeps a RUN/MEMWAIT/HALTED |
// |           FSM and saturating stall/flush performance counters.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pipe_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dren,
  input  logic             exmem_dwen,
  input  logic             exmem_halt,
  input  logic             dcex_dren,
  input  logic             dcex_wen,
  input  logic [REG_W-1:0] dcex_wsel,
  input  logic [REG_W-1:0] dc_rs,
  input  logic [REG_W-1:0] dc_rt,
  input  logic             dc_uses_rt,
  input  logic             ex_redirect,
  output logic             pc_en,
  output logic             ifdc_en,
  output logic             dcex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifdc_flush,
  output logic             dcex_flush,
  output logic             exmem_flush,
  output logic             halt,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  // en_v = {pc, ifdc, dcex, exmem, memwb}; fl_v = {ifdc, dcex, exmem}
  logic [4:0]         en_v;
  logic [2:0]         fl_v;
  logic               mem_op;
  logic               dmem_stall;
  logic               load_use;
  logic               redirect_fire;
  logic               any_hold;

  // Hazard detection: memory op waiting on dmem, and a load whose result
  // the instruction in decode needs (r0 never creates a dependency).
  always_comb begin
    mem_op     = exmem_dren | exmem_dwen;
    dmem_stall = mem_op & ~dhit;
    load_use   = dcex_dren & dcex_wen & (dcex_wsel != '0) &
                 ((dcex_wsel == dc_rs) | (dc_uses_rt & (dcex_wsel == dc_rt)));
  end

  // Prioritised enable/flush decision plus next-state and counter update.
  always_comb begin
    en_v          = 5'b00000;
    fl_v          = 3'b000;
    redirect_fire = 1'b0;
    state_d       = state_q;

    if (state_q == HALTED) begin
      // Frozen until reset.
      state_d = HALTED;
    end else if (dmem_stall) begin
      state_d = MEMWAIT;
    end else begin
      if (!ihit) begin
        // Fetch not ready: hold front end and EX (keeps any pending
        // redirect alive), drain MEM/WB and bubble into ex_mem.
        en_v = 5'b00011;
        fl_v = 3'b001;
      end else if (ex_redirect) begin
        en_v          = 5'b11111;
        fl_v          = 3'b110;
        redirect_fire = 1'b1;
      end else if (load_use) begin
        en_v = 5'b00111;
        fl_v = 3'b010;
      end else begin
        en_v = 5'b11111;
      end
      state_d = exmem_halt ? HALTED : RUN;
    end

    // Latch controls are quiet while reset is held.
    if (!nRST) begin
      en_v          = 5'b00000;
      fl_v          = 3'b000;
      redirect_fire = 1'b0;
    end

    any_hold    = ~(&en_v);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (any_hold && (state_q != HALTED) && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (redirect_fire && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  // FSM state and performance counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_en       = en_v[4];
  assign ifdc_en     = en_v[3];
  assign dcex_en     = en_v[2];
  assign exmem_en    = en_v[1];
  assign memwb_en    = en_v[0];
  assign ifdc_flush  = fl_v[2];
  assign dcex_flush  = fl_v[1];
  assign exmem_flush = fl_v[0];
  assign halt        = (state_q == HALTED);
  assign state       = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_pipe_ctrl                                               |
// | Purpose : Directed bench for pipe_ctrl. Each stimulus cycle pushes   |
// |           its hand-computed expected outputs into a scoreboard; a    |
// |           monitor pops and compares on the falling edge.             |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_pipe_ctrl;

  localparam int CNT_W = 4;  // narrow counters so saturation is reachable
  localparam int REG_W = 5;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, exmem_dren, exmem_dwen, exmem_halt;
  logic             dcex_dren, dcex_wen, dc_uses_rt, ex_redirect;
  logic [REG_W-1:0] dcex_wsel, dc_rs, dc_rt;
  logic             pc_en, ifdc_en, dcex_en, exmem_en, memwb_en;
  logic             ifdc_flush, dcex_flush, exmem_flush, halt;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic [4:0]       en;
    logic [2:0]       fl;
    logic [1:0]       st;
    logic             hl;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  pipe_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dren(exmem_dren), .exmem_dwen(exmem_dwen), .exmem_halt(exmem_halt),
    .dcex_dren(dcex_dren), .dcex_wen(dcex_wen), .dcex_wsel(dcex_wsel),
    .dc_rs(dc_rs), .dc_rt(dc_rt), .dc_uses_rt(dc_uses_rt),
    .ex_redirect(ex_redirect),
    .pc_en(pc_en), .ifdc_en(ifdc_en), .dcex_en(dcex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifdc_flush(ifdc_flush), .dcex_flush(dcex_flush), .exmem_flush(exmem_flush),
    .halt(halt), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // Monitor: outputs are valid every cycle; compare away from the rising edge.
  always @(negedge CLK) begin
    exp_t  e, a;
    string t;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      a.en = {pc_en, ifdc_en, dcex_en, exmem_en, memwb_en};
      a.fl = {ifdc_flush, dcex_flush, exmem_flush};
      a.st = state;
      a.hl = halt;
      a.sc = stall_cnt;
      a.fc = flush_cnt;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got en=%b fl=%b st=%0d halt=%b stall=%0d flush=%0d, want en=%b fl=%b st=%0d halt=%b stall=%0d flush=%0d",
                 t, a.en, a.fl, a.st, a.hl, a.sc, a.fc, e.en, e.fl, e.st, e.hl, e.sc, e.fc);
      end
    end
  end

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; exmem_dren = 1'b0; exmem_dwen = 1'b0;
    exmem_halt = 1'b0; dcex_dren = 1'b0; dcex_wen = 1'b0; dc_uses_rt = 1'b0;
    ex_redirect = 1'b0; dcex_wsel = '0; dc_rs = '0; dc_rt = '0;
  endtask

  // Push expectation for the cycle whose inputs are already applied, then
  // advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [4:0] en, input logic [2:0] fl,
                     input logic [1:0] st, input logic hl, input int sc, input int fc);
    exp_t e;
    e.en = en; e.fl = fl; e.st = st; e.hl = hl;
    e.sc = CNT_W'(sc); e.fc = CNT_W'(fc);
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0;
    idle();
    @(posedge CLK); #1;
    cyc("reset", 5'b00000, 3'b000, 0, 0, 0, 0);
    nRST = 1'b1;

    // Free-running, no hazards.
    for (int i = 0; i < 10; i++) cyc("idle", 5'b11111, 3'b000, 0, 0, 0, 0);

    // Load waiting three cycles on dmem.
    exmem_dren = 1'b1;
    cyc("dmem_w0", 5'b00000, 3'b000, 0, 0, 0, 0);
    cyc("dmem_w1", 5'b00000, 3'b000, 1, 0, 1, 0);
    cyc("dmem_w2", 5'b00000, 3'b000, 1, 0, 2, 0);
    dhit = 1'b1;
    cyc("dmem_hit", 5'b11111, 3'b000, 1, 0, 3, 0);
    idle();
    cyc("dmem_after", 5'b11111, 3'b000, 0, 0, 3, 0);

    // Load-use on rs.
    dcex_dren = 1'b1; dcex_wen = 1'b1; dcex_wsel = 5'd5; dc_rs = 5'd5;
    cyc("lu_rs", 5'b00111, 3'b010, 0, 0, 3, 0);
    dcex_wsel = 5'd0; dc_rs = 5'd0;
    cyc("lu_r0", 5'b11111, 3'b000, 0, 0, 4, 0);
    // Load-use on rt, only when rt is read.
    dcex_wsel = 5'd7; dc_rt = 5'd7; dc_rs = 5'd3; dc_uses_rt = 1'b1;
    cyc("lu_rt", 5'b00111, 3'b010, 0, 0, 4, 0);
    dc_uses_rt = 1'b0;
    cyc("lu_rt_unused", 5'b11111, 3'b000, 0, 0, 5, 0);

    // Redirect beats load-use.
    dcex_wsel = 5'd5; dc_rs = 5'd5; ex_redirect = 1'b1;
    cyc("redir_lu", 5'b11111, 3'b110, 0, 0, 5, 0);
    idle();
    cyc("redir_after", 5'b11111, 3'b000, 0, 0, 5, 1);

    // Redirect held across an imem stall, applied on ihit.
    ihit = 1'b0; ex_redirect = 1'b1;
    cyc("imem_redir0", 5'b00011, 3'b001, 0, 0, 5, 1);
    cyc("imem_redir1", 5'b00011, 3'b001, 0, 0, 6, 1);
    ihit = 1'b1;
    cyc("imem_redir_hit", 5'b11111, 3'b110, 0, 0, 7, 1);
    idle();
    cyc("imem_after", 5'b11111, 3'b000, 0, 0, 7, 2);

    // Store stalls on dmem too.
    exmem_dwen = 1'b1;
    cyc("store_w0", 5'b00000, 3'b000, 0, 0, 7, 2);
    dhit = 1'b1;
    cyc("store_hit", 5'b11111, 3'b000, 1, 0, 8, 2);
    idle();
    cyc("store_after", 5'b11111, 3'b000, 0, 0, 8, 2);

    // Halt behind a pending load.
    exmem_halt = 1'b1; exmem_dren = 1'b1;
    cyc("halt_wait", 5'b00000, 3'b000, 0, 0, 8, 2);
    dhit = 1'b1;
    cyc("halt_hit", 5'b11111, 3'b000, 1, 0, 9, 2);
    idle();
    cyc("halted0", 5'b00000, 3'b000, 2, 1, 9, 2);
    ex_redirect = 1'b1;
    cyc("halted_redir", 5'b00000, 3'b000, 2, 1, 9, 2);
    ex_redirect = 1'b0; ihit = 1'b0;
    cyc("halted_noihit", 5'b00000, 3'b000, 2, 1, 9, 2);

    // Mid-halt reset pulse.
    idle();
    nRST = 1'b0;
    cyc("reset_mid", 5'b00000, 3'b000, 0, 0, 0, 0);
    nRST = 1'b1;
    cyc("post_reset", 5'b11111, 3'b000, 0, 0, 0, 0);

    // Stall counter saturation.
    ihit = 1'b0;
    for (int i = 0; i < 18; i++)
      cyc("stall_sat", 5'b00011, 3'b001, 0, 0, (i > 15) ? 15 : i, 0);
    idle();
    cyc("stall_sat_end", 5'b11111, 3'b000, 0, 0, 15, 0);

    // Flush counter saturation.
    ex_redirect = 1'b1;
    for (int i = 0; i < 18; i++)
      cyc("flush_sat", 5'b11111, 3'b110, 0, 0, 15, (i > 15) ? 15 : i);
    idle();

    for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(negedge CLK);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
